// File: rtl/instr_mem_if.sv
// Bus between the fetch stage / debug loader and the instruction memory.
// The module takes the slave side; the driving stage takes the master side.
interface instr_mem_if #(
    parameter int PC_SZ     = 32,
    parameter int INST_SZ   = 32,
    parameter int B         = 8,
    parameter int MEM_DEPTH = 64
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic               i_write_en;
    logic [B-1:0]       i_data;
    logic               i_clear;
    logic               i_enable;
    logic               i_flush;
    logic [PC_SZ-1:0]   i_pc;

    logic [INST_SZ-1:0] o_instr;
    logic               o_instr_valid;
    logic               o_halt;
    logic [AW:0]        o_words;
    logic               o_empty;
    logic               o_full;

    modport master (
        output i_write_en, i_data, i_clear, i_enable, i_flush, i_pc,
        input  o_instr, o_instr_valid, o_halt, o_words, o_empty, o_full
    );

    modport slave (
        input  i_write_en, i_data, i_clear, i_enable, i_flush, i_pc,
        output o_instr, o_instr_valid, o_halt, o_words, o_empty, o_full
    );
endinterface

// File: rtl/instr_mem.sv
// Word-organised instruction memory: byte-serial loader plus a one-cycle registered fetch port.
// Out-of-program, flushed or not-yet-loaded fetches return a NOP (all zeros).
//
// state  | meaning
// LD_B0  | waiting for byte 0 of a word (bits [31:24])
// LD_B1  | byte 0 held, waiting for byte 1
// LD_B2  | bytes 0-1 held, waiting for byte 2
// LD_B3  | bytes 0-2 held; next accepted byte completes and writes the word
module instr_mem #(
    parameter int PC_SZ     = 32,
    parameter int INST_SZ   = 32,
    parameter int B         = 8,
    parameter int MEM_DEPTH = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    instr_mem_if.slave bus
);
    localparam int                 AW      = $clog2(MEM_DEPTH);
    localparam logic [AW:0]        DEPTH_W = (AW+1)'(MEM_DEPTH);
    localparam logic [INST_SZ-1:0] HALT    = '1;

    typedef enum logic [1:0] {LD_B0, LD_B1, LD_B2, LD_B3} ld_state_t;

    ld_state_t              ld_state;
    ld_state_t              ld_next;
    logic [INST_SZ-B-1:0]   partial;
    logic [AW:0]            words;
    logic                   full;
    logic                   byte_accept;
    logic                   word_write;
    logic [INST_SZ-1:0]     word_new;
    logic [INST_SZ-1:0]     mem [MEM_DEPTH];

    logic [AW-1:0]          idx;
    logic                   pc_hi_zero;
    logic                   in_range;
    logic [INST_SZ-1:0]     rd_word;
    logic [INST_SZ-1:0]     instr_q;
    logic                   valid_q;
    logic                   halt_q;
    logic                   unused_pc_lsb;

    // ---------------- load path ----------------
    assign full        = (words == DEPTH_W);
    assign byte_accept = bus.i_write_en && !bus.i_clear && !full;
    assign word_new    = {partial, bus.i_data};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ld_state <= LD_B0;
        end else begin
            ld_state <= ld_next;
        end
    end

    always_comb begin
        ld_next    = ld_state;
        word_write = 1'b0;
        if (bus.i_clear) begin
            ld_next = LD_B0;
        end else if (byte_accept) begin
            case (ld_state)
                LD_B0: ld_next = LD_B1;
                LD_B1: ld_next = LD_B2;
                LD_B2: ld_next = LD_B3;
                LD_B3: begin
                    ld_next    = LD_B0;
                    word_write = 1'b1;
                end
                default: ld_next = LD_B0;
            endcase
        end
    end

    // Earlier bytes shift upward so byte 0 ends in the top lane of the word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            partial <= '0;
        end else if (byte_accept && (ld_state != LD_B3)) begin
            partial <= {partial[INST_SZ-2*B-1:0], bus.i_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            words <= '0;
        end else if (bus.i_clear) begin
            words <= '0;
        end else if (word_write) begin
            words <= words + (AW+1)'(1);
        end
    end

    // word_write implies !full, so words[AW-1:0] is a valid slot here.
    always_ff @(posedge i_clk) begin
        if (word_write) begin
            mem[words[AW-1:0]] <= word_new;
        end
    end

    // ---------------- fetch path ----------------
    assign idx           = bus.i_pc[AW+1:2];
    assign pc_hi_zero    = (bus.i_pc[PC_SZ-1:AW+2] == '0);
    assign in_range      = pc_hi_zero && ({1'b0, idx} < words);
    assign rd_word       = mem[idx];
    assign unused_pc_lsb = ^bus.i_pc[1:0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else if (bus.i_flush) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else if (bus.i_enable) begin
            if (in_range) begin
                instr_q <= rd_word;
                valid_q <= 1'b1;
                halt_q  <= (rd_word == HALT);
            end else begin
                instr_q <= '0;
                valid_q <= 1'b0;
                halt_q  <= 1'b0;
            end
        end
    end

    assign bus.o_instr       = instr_q;
    assign bus.o_instr_valid = valid_q;
    assign bus.o_halt        = halt_q;
    assign bus.o_words       = words;
    assign bus.o_empty       = (words == '0);
    assign bus.o_full        = full;
endmodule
